// File: rtl/pipe_skid_stage.sv
// Handshaked pipeline stage register with a two-entry skid buffer.
// The output register holds the head entry; the skid register catches one extra entry
// so that in_ready_o comes straight from a flop and never depends on out_ready_i.
// Control payload is replaced by CTRL_NOP whenever nothing valid is presented; the data
// payload is either held or zeroed depending on CLEAR_DATA.
module pipe_skid_stage #(
  parameter int unsigned        DATA_W     = 96,
  parameter int unsigned        CTRL_W     = 16,
  parameter logic [CTRL_W-1:0]  CTRL_NOP   = '0,
  parameter bit                 CLEAR_DATA = 1'b0,
  parameter int unsigned        CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [CTRL_W-1:0]   out_ctrl_q, out_ctrl_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    bubble_q, bubble_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  // Next-state and payload steering; flush overrides every handshake.
  always_comb begin
    state_d     = state_q;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush_i) begin
      state_d    = StEmpty;
      out_ctrl_d = CTRL_NOP;
      if (CLEAR_DATA) begin
        out_data_d = '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d    = StOne;
            out_ctrl_d = in_ctrl_i;
            out_data_d = in_data_i;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            out_ctrl_d = in_ctrl_i;
            out_data_d = in_data_i;
          end else if (in_fire) begin
            state_d     = StTwo;
            skid_ctrl_d = in_ctrl_i;
            skid_data_d = in_data_i;
          end else if (out_fire) begin
            state_d    = StEmpty;
            out_ctrl_d = CTRL_NOP;
            if (CLEAR_DATA) begin
              out_data_d = '0;
            end
          end
        end
        StTwo: begin
          if (out_fire) begin
            state_d    = StOne;
            out_ctrl_d = skid_ctrl_q;
            out_data_d = skid_data_q;
          end
        end
        default: begin
          state_d    = StEmpty;
          out_ctrl_d = CTRL_NOP;
        end
      endcase
    end

    // Handshake outputs are registered from the next state.
    out_valid_d = (state_d != StEmpty);
    in_ready_d  = (state_d != StTwo);
  end

  // Saturating count of cycles where downstream was ready but starved.
  always_comb begin
    bubble_d = bubble_q;
    if (!out_valid_q && out_ready_i && !flush_i && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  // State, payload and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_ctrl_q  <= CTRL_NOP;
      out_data_q  <= '0;
      skid_ctrl_q <= CTRL_NOP;
      skid_data_q <= '0;
      bubble_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      bubble_q    <= bubble_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_ctrl_o   = out_ctrl_q;
  assign out_data_o   = out_data_q;
  assign occupancy_o  = state_q;
  assign bubble_cnt_o = bubble_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: two instances share stimulus, one holding data on drain
// (CTRL_NOP 0x00F3, 3-bit bubble counter) and one zeroing data (CTRL_NOP 0, 16-bit counter).
// A queue model tracks stored entries; tick() compares both instances against it each cycle.
module tb_pipe_skid_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] NOP0 = 16'h00F3;
  localparam logic [CW-1:0] NOP1 = 16'h0000;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl0;
  logic [DW-1:0] out_data0;
  logic [1:0]    occ0;
  logic [2:0]    bub0;

  logic          in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl1;
  logic [DW-1:0] out_data1;
  logic [1:0]    occ1;
  logic [15:0]   bub1;

  int checks = 0;
  int errors = 0;

  logic [CW+DW-1:0] q[$];
  logic [DW-1:0]    last_shown;
  int               model_bub0;
  int               model_bub1;

  pipe_skid_stage #(
    .DATA_W     (DW),
    .CTRL_W     (CW),
    .CTRL_NOP   (NOP0),
    .CLEAR_DATA (1'b0),
    .CNT_W      (3)
  ) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready0),
    .in_ctrl_i    (in_ctrl),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid0),
    .out_ready_i  (out_ready),
    .out_ctrl_o   (out_ctrl0),
    .out_data_o   (out_data0),
    .occupancy_o  (occ0),
    .bubble_cnt_o (bub0)
  );

  pipe_skid_stage #(
    .DATA_W     (DW),
    .CTRL_W     (CW),
    .CTRL_NOP   (NOP1),
    .CLEAR_DATA (1'b1),
    .CNT_W      (16)
  ) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready1),
    .in_ctrl_i    (in_ctrl),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid1),
    .out_ready_i  (out_ready),
    .out_ctrl_o   (out_ctrl1),
    .out_data_o   (out_data1),
    .occupancy_o  (occ1),
    .bubble_cnt_o (bub1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock cycle: compare against the model at the falling edge, advance the model with
  // the handshakes of the coming rising edge, then check the bubble counters after it.
  task automatic tick();
    int   sz;
    logic in_fire;
    logic out_fire;
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      last_shown = '0;
      model_bub0 = 0;
      model_bub1 = 0;
    end else begin
      sz = q.size();
      checks++;
      if (occ0 !== 2'(sz) || occ1 !== 2'(sz)) begin
        errors++;
        $display("FAIL sb_occupancy got %0d/%0d want %0d", occ0, occ1, sz);
      end
      checks++;
      if (in_ready0 !== (sz < 2) || in_ready1 !== (sz < 2)) begin
        errors++;
        $display("FAIL sb_in_ready got %b/%b want %b", in_ready0, in_ready1, (sz < 2));
      end
      checks++;
      if (out_valid0 !== (sz > 0) || out_valid1 !== (sz > 0)) begin
        errors++;
        $display("FAIL sb_out_valid got %b/%b want %b", out_valid0, out_valid1, (sz > 0));
      end
      checks++;
      if (sz > 0) begin
        if ({out_ctrl0, out_data0} !== q[0] || {out_ctrl1, out_data1} !== q[0]) begin
          errors++;
          $display("FAIL sb_head got %h/%h want %h", {out_ctrl0, out_data0},
                   {out_ctrl1, out_data1}, q[0]);
        end
        last_shown = q[0][DW-1:0];
      end else begin
        if ({out_ctrl0, out_data0} !== {NOP0, last_shown} ||
            {out_ctrl1, out_data1} !== {NOP1, {DW{1'b0}}}) begin
          errors++;
          $display("FAIL sb_empty_payload got %h/%h want %h/%h", {out_ctrl0, out_data0},
                   {out_ctrl1, out_data1}, {NOP0, last_shown}, {NOP1, {DW{1'b0}}});
        end
      end
      in_fire  = in_valid && (sz < 2);
      out_fire = (sz > 0) && out_ready;
      if (out_fire) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_fire) q.push_back({in_ctrl, in_data});
      if (sz == 0 && out_ready && !flush) begin
        if (model_bub0 < 7) model_bub0++;
        if (model_bub1 < 65535) model_bub1++;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (bub0 !== 3'(model_bub0) || bub1 !== 16'(model_bub1)) begin
      errors++;
      $display("FAIL sb_bubble got %0d/%0d want %0d/%0d", bub0, bub1, model_bub0, model_bub1);
    end
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid0, in_ready0, occ0, bub0} !== {1'b0, 1'b1, 2'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_flags got %b want %b", {out_valid0, in_ready0, occ0, bub0},
               {1'b0, 1'b1, 2'd0, 3'd0});
    end
    checks++;
    if ({out_ctrl0, out_data0} !== {NOP0, 32'h0} || {out_ctrl1, out_data1} !== {NOP1, 32'h0})
    begin
      errors++;
      $display("FAIL reset_payload got %h/%h", {out_ctrl0, out_data0}, {out_ctrl1, out_data1});
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_ctrl = CW'(16'h0100 + i);
      in_data = DW'(i);
      tick();
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== DW'(i) || in_ready0 !== 1'b1 || occ0 !== 2'd1)
      begin
        errors++;
        $display("FAIL stream_%0d got v=%b d=%h r=%b o=%0d want v=1 d=%h r=1 o=1", i,
                 out_valid0, out_data0, in_ready0, occ0, DW'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0A0A;
    in_data   = 32'h11;
    tick();
    in_ctrl   = 16'h0B0B;
    in_data   = 32'h22;
    tick();
    in_valid  = 1'b0;
    checks++;
    if (occ0 !== 2'd2 || in_ready0 !== 1'b0 || out_data0 !== 32'h11) begin
      errors++;
      $display("FAIL bp_full got o=%0d r=%b d=%h want o=2 r=0 d=11", occ0, in_ready0, out_data0);
    end
    tick();
    tick();
    checks++;
    if (out_data0 !== 32'h11 || out_ctrl0 !== 16'h0A0A) begin
      errors++;
      $display("FAIL bp_stable got %h/%h want 0a0a/11", out_ctrl0, out_data0);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data0 !== 32'h22 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got d=%h r=%b want d=22 r=1", out_data0, in_ready0);
    end
    tick();
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0C01;
    in_data   = 32'h33;
    tick();
    in_ctrl   = 16'h0C02;
    in_data   = 32'h44;
    tick();
    flush     = 1'b1;
    in_ctrl   = 16'hDEAD;
    in_data   = 32'hDEADBEEF;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0 || out_ctrl0 !== 16'h00F3 || occ0 !== 2'd0) begin
      errors++;
      $display("FAIL flush_two got v=%b c=%h o=%0d want v=0 c=00f3 o=0", out_valid0,
               out_ctrl0, occ0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0C03;
    in_data   = 32'h55;
    tick();
    in_valid  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_clear_data();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0D0D;
    in_data   = 32'h5A5A;
    tick();
    in_valid  = 1'b0;
    tick();
    checks++;
    if (out_data0 !== 32'h5A5A || out_ctrl0 !== NOP0) begin
      errors++;
      $display("FAIL clear0_hold got %h/%h want 00f3/5a5a", out_ctrl0, out_data0);
    end
    checks++;
    if (out_data1 !== 32'h0 || out_ctrl1 !== NOP1) begin
      errors++;
      $display("FAIL clear1_zero got %h/%h want 0000/0", out_ctrl1, out_data1);
    end
  endtask

  task automatic test_bubble();
    reset_dut();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (bub0 !== 3'((i > 7) ? 7 : i)) begin
        errors++;
        $display("FAIL bubble_sat_%0d got %0d want %0d", i, bub0, (i > 7) ? 7 : i);
      end
    end
    reset_dut();
    out_ready = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    checks++;
    if (bub0 !== 3'd2 || bub1 !== 16'd2) begin
      errors++;
      $display("FAIL bubble_flush got %0d/%0d want 2/2", bub0, bub1);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0E01;
    in_data   = 32'h66;
    tick();
    in_ctrl   = 16'h0E02;
    in_data   = 32'h77;
    tick();
    in_valid  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid0, in_ready0, occ0} !== {1'b0, 1'b1, 2'd0} || out_ctrl0 !== NOP0 ||
        out_data0 !== 32'h0 || out_valid1 !== 1'b0 || out_data1 !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got v=%b r=%b o=%0d c=%h d=%h want v=0 r=1 o=0 c=00f3 d=0",
               out_valid0, in_ready0, occ0, out_ctrl0, out_data0);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      in_ctrl   = CW'($urandom);
      in_data   = $urandom;
      tick();
    end
    idle_inputs();
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (occ0 !== 2'd0 || out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL random_drain got o=%0d v=%b want o=0 v=0", occ0, out_valid0);
    end
  endtask

  initial begin
    last_shown = '0;
    model_bub0 = 0;
    model_bub1 = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_clear_data();
    test_bubble();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
